bankgroup_arbiter: RTL and testbench
====================================

BANKGROUP_ARBITER -- requirements
Module: bankgroup_arbiter

Interface
REQ-001 SHALL have parameters: N_REQ, 3, number of requesters; RD_TIMEOUT, 4, max cycles waited for read data.
REQ-002 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  N_REQ  per-requester request, held until gnt.
REQ-006 req_we  in  N_REQ  1=write, 0=read.
REQ-007 req_pattern  in  N_REQ  0=random access, 1=FIFO mode.
REQ-008 req_fifo_sel  in  2*N_REQ  FIFO select, packed, requester i at [2i+1:2i].
REQ-009 req_addr  in  10*N_REQ  random-mode word address, packed.
REQ-010 req_wdata  in  32*N_REQ  write data, packed.
REQ-011 gnt  out  N_REQ  one-hot one-cycle pulse: command accepted.
REQ-012 rvalid  out  N_REQ  one-cycle read-complete pulse to owner.
REQ-013 rdata  out  32  read data, valid with rvalid.
REQ-014 err  out  1  pulse with gnt (illegal command) or with rvalid (read timeout).
REQ-015 flush_req  in  1  level request to flush all bankgroup FIFOs.
REQ-016 flush_done  out  1  one-cycle pulse when flush issued.
REQ-017 bg_en, bg_we, bg_re, bg_pattern, bg_flush  out  1 each  bankgroup controls.
REQ-018 bg_fifo_sel  out  2; bg_addr  out  10; bg_din  out  32  bankgroup command fields.
REQ-019 bg_dout  in  33  bankgroup output, bit 32 = read_valid, [31:0] = data.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ, RD_WAIT, FLUSH.
REQ-021 IDLE: flush_req=1 -> FLUSH (priority over req); else any req -> round-robin pick, capture fields into registers; next state WRITE or READ; none -> stay.
REQ-022 Round-robin: search starts at index after last granted, wrapping N_REQ-1 -> 0; pointer updates only on gnt.
REQ-023 Illegal command (pattern=1, fifo_sel=2'b11): gnt and err pulse in the cycle after capture, no bankgroup access, return to IDLE.
REQ-024 WRITE (1 cycle): bg_en=1, bg_we=1, bg_re=0, captured fields on bg_*; gnt[i]=1; -> IDLE. Write throughput: 1 per 2 cycles.
REQ-025 READ (1 cycle): bg_en=1, bg_re=1, bg_we=0, gnt[i]=1; -> RD_WAIT.
REQ-026 RD_WAIT: bg_en=bg_re=0; bg_dout[32]=1 -> register bg_dout[31:0] into rdata, rvalid[i] next cycle, -> IDLE.
REQ-027 RD_WAIT lasting RD_TIMEOUT cycles without valid (e.g. empty FIFO) -> rvalid[i]+err, rdata=32'hFFFFFFFF, -> IDLE.
REQ-028 Load-to-use latency: read capture at t, gnt t+1, rvalid t+3 minimum.
REQ-029 flush_req during WRITE/READ/RD_WAIT: current transaction completes first, then FLUSH.
REQ-030 FLUSH (1 cycle): bg_flush=1, bg_en=0; flush_done next cycle; pointer -> 0; -> IDLE; flush_req still high then re-flushes.
REQ-031 Outside WRITE/READ: bg_en, bg_we, bg_re, bg_flush=0; bg_addr/bg_din/bg_fifo_sel/bg_pattern hold last value.
REQ-032 All outputs SHALL be registered; no combinational path req -> bg_*.

Reset
REQ-033 rst -> IDLE, pointer 0, gnt/rvalid/err/flush_done 0, all bg_* 0, rdata 0.
REQ-034 rst mid-transaction abandons it: no gnt/rvalid for the aborted request.

Structure
REQ-035 State encodings, RD_TIMEOUT default and bus widths SHALL live in the shared param_define include, alongside A_W and C_L_bus.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (req vector + pointer in, one-hot grant out).

Verification
REQ-037 Req 0 write addr 10'h005 data 32'hA5A5A5A5, pattern 0 -> bg_en=bg_we=1 one cycle, bg_addr 005, gnt[0]; read-back -> rvalid[0], rdata A5A5A5A5.
REQ-038 req=3'b111 held, all reads -> gnt order 0,1,2,0; no requester starved.
REQ-039 FIFO read (pattern 1, fifo_sel 01) on empty FIFO -> after 4 cycles rvalid+err, rdata FFFFFFFF.
REQ-040 pattern 1, fifo_sel 11 -> gnt+err, bg_en never high.
REQ-041 flush_req raised during RD_WAIT -> rvalid first, then bg_flush one cycle, flush_done, next gnt from requester 0.
REQ-042 rst asserted in RD_WAIT -> no rvalid, all outputs 0 next cycle, pointer 0.

Source files
------------

// File: rtl/bankgroup_arbiter_pkg.sv
// Shared definitions for the bankgroup arbiter:
// bus widths, state encodings and command bundle.
package bankgroup_arbiter_pkg;

  localparam int A_W            = 10;
  localparam int C_L_bus        = 32;
  localparam int FS_W           = 2;
  localparam int RD_TIMEOUT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  typedef struct packed {
    logic               we;
    logic               pattern;
    logic [FS_W-1:0]    fifo_sel;
    logic [A_W-1:0]     addr;
    logic [C_L_bus-1:0] wdata;
  } cmd_t;

  function automatic logic is_illegal(input cmd_t c);
    return c.pattern && (c.fifo_sel == 2'b11);
  endfunction

endpackage

// File: rtl/bankgroup_arbiter_rr_arbiter.sv
// Round-robin picker: search starts at ptr and wraps.
// Combinational; the caller registers the result.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/bankgroup_arbiter.sv
// Arbitrates N_REQ requesters onto one bankgroup port,
// with read timeout, illegal-command reject and flush.
module bankgroup_arbiter
  import bankgroup_arbiter_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ-1:0]         req_pattern,
  input  logic [FS_W*N_REQ-1:0]    req_fifo_sel,
  input  logic [A_W*N_REQ-1:0]     req_addr,
  input  logic [C_L_bus*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [C_L_bus-1:0]       rdata,
  output logic                     err,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     bg_en,
  output logic                     bg_we,
  output logic                     bg_re,
  output logic                     bg_pattern,
  output logic                     bg_flush,
  output logic [FS_W-1:0]          bg_fifo_sel,
  output logic [A_W-1:0]           bg_addr,
  output logic [C_L_bus-1:0]       bg_din,
  input  logic [C_L_bus:0]         bg_dout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [PW-1:0]     ptr;
  logic [N_REQ-1:0]  owner;
  logic [CW-1:0]     wait_cnt;

  logic [N_REQ-1:0]  pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  cmd_t              cmd_in;

  logic              pick;
  logic              illegal;
  logic              rd_hit;
  logic              timeout;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    cmd_in.we       = req_we[pick_idx];
    cmd_in.pattern  = req_pattern[pick_idx];
    cmd_in.fifo_sel = req_fifo_sel[FS_W*pick_idx +: FS_W];
    cmd_in.addr     = req_addr[A_W*pick_idx +: A_W];
    cmd_in.wdata    = req_wdata[C_L_bus*pick_idx +: C_L_bus];
  end

  assign illegal = is_illegal(cmd_in);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // An illegal command still needs one busy cycle for its
  // gnt/err pulse, so it rides through WRITE with bg_en low.
  always_comb begin
    state_next = state;
    pick       = 1'b0;
    rd_hit     = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (flush_req) begin
          state_next = S_FLUSH;
        end else if (pick_any) begin
          pick       = 1'b1;
          state_next = (illegal || cmd_in.we) ? S_WRITE : S_READ;
        end
      end
      S_WRITE: state_next = S_IDLE;
      S_READ:  state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bg_dout[C_L_bus]) begin
          rd_hit     = 1'b1;
          state_next = S_IDLE;
        end else if (wait_cnt == CW'(RD_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_FLUSH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      owner       <= '0;
      wait_cnt    <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      flush_done  <= 1'b0;
      bg_en       <= 1'b0;
      bg_we       <= 1'b0;
      bg_re       <= 1'b0;
      bg_pattern  <= 1'b0;
      bg_flush    <= 1'b0;
      bg_fifo_sel <= '0;
      bg_addr     <= '0;
      bg_din      <= '0;
    end else begin
      gnt        <= '0;
      rvalid     <= '0;
      err        <= 1'b0;
      flush_done <= 1'b0;
      bg_en      <= 1'b0;
      bg_we      <= 1'b0;
      bg_re      <= 1'b0;
      bg_flush   <= 1'b0;

      if (pick) begin
        owner <= pick_gnt;
        gnt   <= pick_gnt;
        ptr   <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
        if (illegal) begin
          err <= 1'b1;
        end else begin
          bg_en       <= 1'b1;
          bg_we       <= cmd_in.we;
          bg_re       <= !cmd_in.we;
          bg_pattern  <= cmd_in.pattern;
          bg_fifo_sel <= cmd_in.fifo_sel;
          bg_addr     <= cmd_in.addr;
          bg_din      <= cmd_in.wdata;
        end
      end

      if (state == S_READ)
        wait_cnt <= '0;
      else if (state == S_RD_WAIT)
        wait_cnt <= wait_cnt + CW'(1);

      if (rd_hit) begin
        rvalid <= owner;
        rdata  <= bg_dout[C_L_bus-1:0];
      end

      if (timeout) begin
        rvalid <= owner;
        err    <= 1'b1;
        rdata  <= '1;
      end

      if (state == S_IDLE && flush_req)
        bg_flush <= 1'b1;

      if (state == S_FLUSH) begin
        flush_done <= 1'b1;
        ptr        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bankgroup_arbiter.sv
// Directed bench for bankgroup_arbiter with a small
// memory-backed bankgroup model (FIFO reads never return).
module tb_bankgroup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_we, req_pattern;
  logic [5:0]  req_fifo_sel;
  logic [29:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        err, flush_req, flush_done;
  logic        bg_en, bg_we, bg_re, bg_pattern, bg_flush;
  logic [1:0]  bg_fifo_sel;
  logic [9:0]  bg_addr;
  logic [31:0] bg_din;
  logic [32:0] bg_dout = '0;

  logic [31:0] mem [0:1023];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bankgroup_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_pattern  (req_pattern),
    .req_fifo_sel (req_fifo_sel),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .err          (err),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .bg_en        (bg_en),
    .bg_we        (bg_we),
    .bg_re        (bg_re),
    .bg_pattern   (bg_pattern),
    .bg_flush     (bg_flush),
    .bg_fifo_sel  (bg_fifo_sel),
    .bg_addr      (bg_addr),
    .bg_din       (bg_din),
    .bg_dout      (bg_dout)
  );

  always @(posedge clk) begin
    if (bg_en && bg_we) mem[bg_addr] <= bg_din;
    bg_dout <= {bg_en && bg_re && !bg_pattern, mem[bg_addr]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    req          = '0;
    req_we       = '0;
    req_pattern  = '0;
    req_fifo_sel = '0;
    req_addr     = {3{10'h005}};
    req_wdata    = '0;
    flush_req    = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_rv", 64'(rvalid), 64'h0);
    chk("rst_ctl", 64'({err, flush_done, bg_en, bg_we,
                        bg_re, bg_pattern, bg_flush}), 64'h0);
    chk("rst_bus", 64'({bg_fifo_sel, bg_addr}), 64'h0);
    chk("rst_din", 64'(bg_din), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    rst = 1'b0;
    tick();

    // write then read back, requester 0
    req             = 3'b001;
    req_we          = 3'b001;
    req_wdata[31:0] = 32'hA5A5A5A5;
    tick();
    chk("wr_gnt", 64'(gnt), 64'h1);
    chk("wr_ctl", 64'({bg_en, bg_we, bg_re}), 64'b110);
    chk("wr_addr", 64'(bg_addr), 64'h005);
    chk("wr_din", 64'(bg_din), 64'hA5A5A5A5);
    req = '0;
    tick();
    chk("wr_end", 64'({bg_en, bg_we, gnt}), 64'h0);
    chk("wr_hold", 64'(bg_addr), 64'h005);
    req    = 3'b001;
    req_we = '0;
    tick();
    chk("rd_gnt", 64'(gnt), 64'h1);
    chk("rd_ctl", 64'({bg_en, bg_re, bg_we}), 64'b110);
    req = '0;
    tick();
    chk("rd_wait", 64'({bg_en, bg_re, rvalid}), 64'h0);
    tick();
    chk("rd_rv", 64'(rvalid), 64'h1);
    chk("rd_data", 64'(rdata), 64'hA5A5A5A5);
    chk("rd_err", 64'(err), 64'h0);

    // round robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", 64'(gnt), 64'(3'b001 << (k % 3)));
      tick();
      tick();
      chk("rr_rv", 64'(rvalid), 64'(3'b001 << (k % 3)));
      chk("rr_data", 64'(rdata), 64'hA5A5A5A5);
    end
    req = '0;

    // empty FIFO read times out, requester 1
    req_pattern  = 3'b010;
    req_fifo_sel = 6'b00_01_00;
    req          = 3'b010;
    tick();
    chk("to_gnt", 64'(gnt), 64'h2);
    chk("to_ctl", 64'({bg_en, bg_re, bg_pattern}), 64'b111);
    chk("to_sel", 64'(bg_fifo_sel), 64'h1);
    req = '0;
    repeat (4) tick();
    chk("to_wait", 64'(rvalid), 64'h0);
    tick();
    chk("to_rv", 64'(rvalid), 64'h2);
    chk("to_err", 64'(err), 64'h1);
    chk("to_data", 64'(rdata), 64'hFFFFFFFF);

    // illegal command, requester 2
    req_pattern  = 3'b100;
    req_fifo_sel = 6'b11_00_00;
    req          = 3'b100;
    tick();
    chk("il_gnt", 64'(gnt), 64'h4);
    chk("il_err", 64'(err), 64'h1);
    chk("il_en", 64'(bg_en), 64'h0);
    req = '0;
    tick();
    chk("il_end", 64'({gnt, err, bg_en}), 64'h0);

    // flush raised during RD_WAIT
    req_pattern  = '0;
    req_fifo_sel = '0;
    req          = 3'b010;
    tick();
    chk("fl_gnt", 64'(gnt), 64'h2);
    req = '0;
    tick();
    flush_req = 1'b1;
    req       = 3'b111;
    tick();
    chk("fl_rv", 64'(rvalid), 64'h2);
    chk("fl_early", 64'(bg_flush), 64'h0);
    tick();
    chk("fl_flush", 64'({bg_flush, bg_en, gnt}), 64'h10);
    tick();
    chk("fl_done", 64'({flush_done, bg_flush}), 64'b10);
    flush_req = 1'b0;
    tick();
    chk("fl_next", 64'(gnt), 64'h1);

    // reset while in RD_WAIT
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("ra_rv", 64'({rvalid, gnt}), 64'h0);
    chk("ra_ctl", 64'({err, flush_done, bg_en, bg_we,
                       bg_re, bg_flush, bg_pattern}), 64'h0);
    chk("ra_bus", 64'({bg_fifo_sel, bg_addr}), 64'h0);
    chk("ra_din", 64'(bg_din), 64'h0);
    chk("ra_rdata", 64'(rdata), 64'h0);
    rst = 1'b0;
    req = 3'b111;
    tick();
    chk("ra_ptr", 64'(gnt), 64'h1);
    req = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
